// File: rtl/i2c_sht40_target_if.sv
// ---------------------------------------------------------------------------
// i2c_sht40_target_if
// Bundles the I2C bus levels shared by the SHT40 stand-in target and whatever
// plays the master side (i2c_master in loopback, the bench in simulation).
//   Scl_In  : raw SCL level seen on the bus (asynchronous to clk)
//   Sda_In  : raw SDA level seen on the bus (wired-AND of all drivers)
//   Sda_Out : target's open-drain control, 1 = release, 0 = pull low
// ---------------------------------------------------------------------------
interface i2c_sht40_target_if;
    logic Scl_In;
    logic Sda_In;
    logic Sda_Out;

    modport master (
        output Scl_In,
        output Sda_In,
        input  Sda_Out
    );

    modport slave (
        input  Scl_In,
        input  Sda_In,
        output Sda_Out
    );
endinterface

// File: rtl/i2c_sht40_target.sv
// ---------------------------------------------------------------------------
// i2c_sht40_target
// Synthesizable I2C target emulating an SHT40 humidity/temperature sensor.
// Accepts the measure command at TARGET_ADDR, stays busy for MEAS_CYCLES clk,
// then returns T_msb, T_lsb, CRC, RH_msb, RH_lsb, CRC on a read.
// Ports:
//   clk          : system clock
//   Reset_N      : synchronous active-low reset
//   bus          : I2C bus levels (slave modport: Scl_In, Sda_In, Sda_Out)
//   Temp_Data    : raw temperature word, captured when the command is accepted
//   RH_Data      : raw humidity word, captured when the command is accepted
//   Busy         : high while a measurement is pending
//   Cmd_Accepted : one-clk pulse when the measure command is ACKed
//   Read_Done    : one-clk pulse when the 6th byte's ACK/NACK is sampled
// ---------------------------------------------------------------------------
module i2c_sht40_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h44,
    parameter logic [7:0] MEAS_CMD    = 8'hE0,
    parameter int         MEAS_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 Reset_N,
    i2c_sht40_target_if.slave    bus,
    input  logic [15:0]          Temp_Data,
    input  logic [15:0]          RH_Data,
    output logic                 Busy,
    output logic                 Cmd_Accepted,
    output logic                 Read_Done
);

    localparam int CNT_W = $clog2(MEAS_CYCLES + 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] CMD       = 3'd3;
    localparam logic [2:0] CMD_ACK   = 3'd4;
    localparam logic [2:0] TX_BYTE   = 3'd5;
    localparam logic [2:0] TX_ACK    = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

    logic             scl_meta, scl_sync, scl_prev;
    logic             sda_meta, sda_sync, sda_prev;
    logic [2:0]       state;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;
    logic             rw_bit;
    logic [2:0]       byte_idx;
    logic [CNT_W-1:0] busy_cnt;
    logic             have_meas;
    logic [15:0]      t_lat, rh_lat;
    logic [7:0]       crc_t, crc_rh;
    logic             sda_out_r;
    logic [7:0]       tx_byte;
    logic [7:0]       rx_byte;
    logic             scl_rise, scl_fall, start_det, stop_det;

    // CRC-8, poly 0x31, init 0xFF, MSB first, no reflection or final XOR.
    function automatic logic [7:0] crc8(input logic [15:0] data);
        logic [7:0] crc;
        crc = 8'hFF;
        for (int i = 15; i >= 0; i--) begin
            if (crc[7] ^ data[i]) crc = {crc[6:0], 1'b0} ^ 8'h31;
            else                  crc = {crc[6:0], 1'b0};
        end
        return crc;
    endfunction

    // Edge and bus-condition detection on the synchronized levels.
    assign scl_rise  =  scl_sync & ~scl_prev;
    assign scl_fall  = ~scl_sync &  scl_prev;
    assign start_det =  sda_prev & ~sda_sync & scl_sync & scl_prev;
    assign stop_det  = ~sda_prev &  sda_sync & scl_sync & scl_prev;
    assign rx_byte   = {shift[6:0], sda_sync};
    assign bus.Sda_Out = sda_out_r;

    // Byte served for the current read index; index 6 and 7 never occur,
    // and bytes after the 6th read as 0xFF because SDA stays released.
    always_comb begin
        tx_byte = 8'hFF;
        case (byte_idx)
            3'd0:    tx_byte = t_lat[15:8];
            3'd1:    tx_byte = t_lat[7:0];
            3'd2:    tx_byte = crc_t;
            3'd3:    tx_byte = rh_lat[15:8];
            3'd4:    tx_byte = rh_lat[7:0];
            3'd5:    tx_byte = crc_rh;
            default: tx_byte = 8'hFF;
        endcase
    end

    // Synchronizers, busy timer and the bus protocol FSM. STOP/START are
    // checked before any per-state action so they win in the same clk.
    always_ff @(posedge clk) begin
        if (!Reset_N) begin
            scl_meta     <= 1'b1;
            scl_sync     <= 1'b1;
            scl_prev     <= 1'b1;
            sda_meta     <= 1'b1;
            sda_sync     <= 1'b1;
            sda_prev     <= 1'b1;
            state        <= IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            rw_bit       <= 1'b0;
            byte_idx     <= '0;
            busy_cnt     <= '0;
            Busy         <= 1'b0;
            have_meas    <= 1'b0;
            t_lat        <= '0;
            rh_lat       <= '0;
            crc_t        <= '0;
            crc_rh       <= '0;
            sda_out_r    <= 1'b1;
            Cmd_Accepted <= 1'b0;
            Read_Done    <= 1'b0;
        end else begin
            scl_meta     <= bus.Scl_In;
            scl_sync     <= scl_meta;
            scl_prev     <= scl_sync;
            sda_meta     <= bus.Sda_In;
            sda_sync     <= sda_meta;
            sda_prev     <= sda_sync;
            Cmd_Accepted <= 1'b0;
            Read_Done    <= 1'b0;

            if (Busy) begin
                busy_cnt <= busy_cnt - CNT_W'(1);
                if (busy_cnt == CNT_W'(1)) Busy <= 1'b0;
            end

            if (stop_det) begin
                state     <= IDLE;
                sda_out_r <= 1'b1;
            end else if (start_det) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                sda_out_r <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    // Collect address + R/W; only a serviceable request gets
                    // an ACK, everything else silently waits for STOP.
                    ADDR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                rw_bit <= sda_sync;
                                if (shift[6:0] != TARGET_ADDR || Busy ||
                                    (sda_sync && !have_meas))
                                    state <= WAIT_STOP;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_out_r <= 1'b0;
                            state     <= ADDR_ACK;
                        end
                    end
                    // The falling edge ending the ACK slot also launches the
                    // first data bit when this is a read.
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw_bit) begin
                                byte_idx  <= '0;
                                sda_out_r <= t_lat[15];
                                state     <= TX_BYTE;
                            end else begin
                                sda_out_r <= 1'b1;
                                state     <= CMD;
                            end
                        end
                    end
                    CMD: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7 && rx_byte != MEAS_CMD)
                                state <= WAIT_STOP;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_out_r    <= 1'b0;
                            Cmd_Accepted <= 1'b1;
                            t_lat        <= Temp_Data;
                            rh_lat       <= RH_Data;
                            crc_t        <= crc8(Temp_Data);
                            crc_rh       <= crc8(RH_Data);
                            have_meas    <= 1'b1;
                            Busy         <= 1'b1;
                            busy_cnt     <= CNT_W'(MEAS_CYCLES);
                            state        <= CMD_ACK;
                        end
                    end
                    CMD_ACK: begin
                        if (scl_fall) begin
                            sda_out_r <= 1'b1;
                            state     <= WAIT_STOP;
                        end
                    end
                    // bit_cnt counts bits already sampled by the master; each
                    // falling edge launches bit (7 - bit_cnt) until all 8 are out.
                    TX_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_out_r <= 1'b1;
                                state     <= TX_ACK;
                            end else begin
                                sda_out_r <= tx_byte[3'd7 - bit_cnt[2:0]];
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            bit_cnt <= '0;
                            if (byte_idx == 3'd5) begin
                                Read_Done <= 1'b1;
                                have_meas <= 1'b0;
                                state     <= WAIT_STOP;
                            end else if (!sda_sync) begin
                                byte_idx <= byte_idx + 3'd1;
                                state    <= TX_BYTE;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    WAIT_STOP: sda_out_r <= 1'b1;
                    default:   state     <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_sht40_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_sht40_target
// Directed bench: a bit-banged I2C master drives the SHT40 stand-in through
// command, busy, read-out, bad-command, wrong-address and reset sequences.
// ---------------------------------------------------------------------------
module tb_i2c_sht40_target;

    localparam int Q = 8;

    logic        clk;
    logic        Reset_N;
    logic [15:0] Temp_Data;
    logic [15:0] RH_Data;
    logic        Busy;
    logic        Cmd_Accepted;
    logic        Read_Done;
    logic        m_sda;

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;
    int cmd_pulses = 0;
    int done_pulses = 0;
    int low_cycles = 0;

    i2c_sht40_target_if bus ();

    i2c_sht40_target dut (
        .clk          (clk),
        .Reset_N      (Reset_N),
        .bus          (bus.slave),
        .Temp_Data    (Temp_Data),
        .RH_Data      (RH_Data),
        .Busy         (Busy),
        .Cmd_Accepted (Cmd_Accepted),
        .Read_Done    (Read_Done)
    );

    // Open-drain bus: the line is low if either side pulls it low.
    assign bus.Sda_In = m_sda & bus.Sda_Out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitors sampled away from the active edge.
    always @(negedge clk) begin
        if (Busy === 1'b1)         busy_cycles++;
        if (Cmd_Accepted === 1'b1) cmd_pulses++;
        if (Read_Done === 1'b1)    done_pulses++;
        if (bus.Sda_Out === 1'b0)  low_cycles++;
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One SCL clock with SDA held at b; returns the line level mid-high.
    task automatic applyStimulus(input logic b, output logic line);
        m_sda = b;
        waitClk(Q);
        bus.Scl_In = 1'b1;
        waitClk(Q);
        line = bus.Sda_In;
        waitClk(Q);
        bus.Scl_In = 1'b0;
        waitClk(Q);
    endtask

    task automatic busStart();
        m_sda = 1'b1;
        bus.Scl_In = 1'b1;
        waitClk(Q);
        m_sda = 1'b0;
        waitClk(Q);
        bus.Scl_In = 1'b0;
        waitClk(Q);
    endtask

    task automatic busStop();
        m_sda = 1'b0;
        waitClk(Q);
        bus.Scl_In = 1'b1;
        waitClk(Q);
        m_sda = 1'b1;
        waitClk(Q);
    endtask

    // Returns the 9th-bit line level: 0 = ACK, 1 = NACK.
    task automatic writeByte(input logic [7:0] data, output logic nack);
        logic l;
        for (int i = 7; i >= 0; i--) applyStimulus(data[i], l);
        applyStimulus(1'b1, nack);
    endtask

    task automatic readByte(input logic master_ack, output logic [7:0] data);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, l);
            data[i] = l;
        end
        applyStimulus(~master_ack, l);
    endtask

    task automatic waitBusyLow();
        int n;
        n = 0;
        while (Busy === 1'b1 && n < 3000) begin
            waitClk(1);
            n++;
        end
        checkOutput("busy_fall_timeout", {31'd0, Busy}, 32'd0);
    endtask

    logic       nack;
    logic       l;
    logic [7:0] rd;
    logic [7:0] exp_bytes [6];

    // Linear directed sequence covering each scenario in turn.
    initial begin
        exp_bytes[0] = 8'hBE; exp_bytes[1] = 8'hEF; exp_bytes[2] = 8'h92;
        exp_bytes[3] = 8'h66; exp_bytes[4] = 8'h66; exp_bytes[5] = 8'h93;
        Reset_N    = 1'b0;
        bus.Scl_In = 1'b1;
        m_sda      = 1'b1;
        Temp_Data  = 16'hBEEF;
        RH_Data    = 16'h6666;
        waitClk(4);
        checkOutput("reset_sda", {31'd0, bus.Sda_Out}, 32'd1);
        checkOutput("reset_busy", {31'd0, Busy}, 32'd0);
        checkOutput("reset_cmd_pulse", {31'd0, Cmd_Accepted}, 32'd0);
        checkOutput("reset_done_pulse", {31'd0, Read_Done}, 32'd0);
        Reset_N = 1'b1;
        waitClk(4);

        $display("[TB] measure command");
        busy_cycles = 0;
        cmd_pulses  = 0;
        busStart();
        writeByte(8'h88, nack);
        checkOutput("cmd_addr_ack", {31'd0, nack}, 32'd0);
        writeByte(8'hE0, nack);
        checkOutput("cmd_byte_ack", {31'd0, nack}, 32'd0);
        busStop();
        checkOutput("cmd_pulse_count", cmd_pulses, 32'd1);
        checkOutput("busy_after_cmd", {31'd0, Busy}, 32'd1);

        $display("[TB] read while busy");
        busStart();
        writeByte(8'h89, nack);
        checkOutput("busy_read_nack", {31'd0, nack}, 32'd1);
        busStop();
        checkOutput("busy_read_sda_released", {31'd0, bus.Sda_Out}, 32'd1);
        waitBusyLow();
        checkOutput("busy_cycle_count", busy_cycles, 32'd1000);

        $display("[TB] six-byte read");
        done_pulses = 0;
        busStart();
        writeByte(8'h89, nack);
        checkOutput("read_addr_ack", {31'd0, nack}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            readByte(i < 5, rd);
            checkOutput($sformatf("read_byte%0d", i), {24'd0, rd}, {24'd0, exp_bytes[i]});
        end
        busStop();
        checkOutput("read_done_count", done_pulses, 32'd1);

        $display("[TB] bad command");
        cmd_pulses = 0;
        busStart();
        writeByte(8'h88, nack);
        checkOutput("bad_cmd_addr_ack", {31'd0, nack}, 32'd0);
        writeByte(8'hFD, nack);
        checkOutput("bad_cmd_nack", {31'd0, nack}, 32'd1);
        busStop();
        checkOutput("bad_cmd_busy", {31'd0, Busy}, 32'd0);
        checkOutput("bad_cmd_no_pulse", cmd_pulses, 32'd0);

        $display("[TB] wrong address");
        low_cycles = 0;
        busStart();
        writeByte(8'h90, nack);
        busStop();
        checkOutput("wrong_addr_nack", {31'd0, nack}, 32'd1);
        checkOutput("wrong_addr_never_driven", low_cycles, 32'd0);

        $display("[TB] reset during T_lsb");
        busStart();
        writeByte(8'h88, nack);
        writeByte(8'hE0, nack);
        busStop();
        waitBusyLow();
        busStart();
        writeByte(8'h89, nack);
        checkOutput("rst_read_addr_ack", {31'd0, nack}, 32'd0);
        readByte(1'b1, rd);
        checkOutput("rst_t_msb", {24'd0, rd}, 32'h0000_00BE);
        // Three 1-bits of 0xEF are out; bit 4 (a 0) is now being driven.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, l);
        checkOutput("rst_pre_sda_low", {31'd0, bus.Sda_Out}, 32'd0);
        Reset_N = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_sda_released", {31'd0, bus.Sda_Out}, 32'd1);
        waitClk(2);
        Reset_N = 1'b1;
        waitClk(4);
        checkOutput("rst_busy", {31'd0, Busy}, 32'd0);
        busStop();
        busStart();
        writeByte(8'h89, nack);
        checkOutput("rst_read_nack", {31'd0, nack}, 32'd1);
        busStop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_sht40_target.md
Name: i2c_sht40_target

Overview:
- Synthesizable I2C target that stands in for an SHT40 sensor at the far end of the bus driven by i2c_master.
- Answers the measure command 0xE0 at address 0x44, runs a measurement-busy interval, then returns 6 bytes on read: T_msb, T_lsb, CRC, RH_msb, RH_lsb, CRC.
- Used in bench and loopback builds: its open-drain Sda_Out joins the shared Sda_Data line beside the master, so the whole master → sht40 decode path runs without silicon.

Parameters:
- TARGET_ADDR, 7'h44, 7-bit bus address this target answers to.
- MEAS_CMD, 8'hE0, only accepted command byte.
- MEAS_CYCLES, 1000, clk cycles the target stays busy after a valid command.

Ports:
- clk  input  1  system clock.
- Reset_N  input  1  synchronous, active-low reset.
- Scl_In  input  1  raw SCL bus level, asynchronous.
- Sda_In  input  1  raw SDA bus level, asynchronous.
- Sda_Out  output  1  open-drain control: 1 = release (Z), 0 = pull low.
- Temp_Data  input  16  raw temperature word, captured at command accept.
- RH_Data  input  16  raw humidity word, captured at command accept.
- Busy  output  1  high while a measurement is pending.
- Cmd_Accepted  output  1  one-clk pulse when MEAS_CMD is ACKed.
- Read_Done  output  1  one-clk pulse when the 6th byte's ACK/NACK is sampled.

Behaviour:
- Reset (Reset_N low at a clk edge): Sda_Out=1, Busy=0, both pulses 0, state IDLE, all counters and latches cleared. Reset mid-transfer releases SDA on the next edge.
- Input sync: Scl_In and Sda_In each pass through a 2-FF synchronizer. Edges are detected on the synced values, so response latency from a bus edge is 3 clk.
- START: synced SDA falls while synced SCL is high. Accepted in any state; a repeated START goes straight to ADDR with the bit counter cleared.
- STOP: synced SDA rises while synced SCL is high. From any state it goes to IDLE and releases SDA.
- Data sampling: SDA is sampled on the SCL rising edge, MSB first.
- SDA drive: SDA changes only on the clk after a detected SCL falling edge and is held until the next SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
- ADDR: shift 8 bits.
  - If addr ≠ TARGET_ADDR → WAIT_STOP, SDA released.
  - Write (W) with Busy=0 → ACK, then CMD.
  - Read (R) with Busy=0 and a measurement latched → ACK, then TX_BYTE with byte index 0.
  - Any request with Busy=1, or R with nothing latched → NACK (SDA released), then WAIT_STOP.
- ACK slot: drive 0 from the falling edge after bit 8 until the falling edge after bit 9, then release.
- CMD: shift 8 bits.
  - Byte == MEAS_CMD → ACK, pulse Cmd_Accepted, latch Temp_Data/RH_Data, load the busy counter with MEAS_CYCLES, Busy=1.
  - Any other byte → NACK, no state change.
  - After either, go to WAIT_STOP.
- Busy counter: decrements each clk and clears Busy at 0. A new valid command while Busy=1 cannot occur, because the address is NACKed.
- TX_BYTE: byte index 0..5 selects T[15:8], T[7:0], CRC(T), RH[15:8], RH[7:0], CRC(RH).
  - The MSB is driven on the falling edge that ends the address ACK slot.
  - Each remaining bit is driven on the following falling edges.
  - A 1 bit is driven as release.
- TX_ACK: SDA released; master ACK/NACK sampled on the 9th SCL rise.
  - ACK with index < 5 → index+1, back to TX_BYTE.
  - NACK → WAIT_STOP.
  - After index 5 (either response): pulse Read_Done, clear the latched-measurement flag, go to WAIT_STOP. Further SCL pulses read 0xFF.
- CRC: CRC-8, polynomial 0x31, init 0xFF, no reflection, no final XOR, computed over the 2 data bytes. Precompute at latch or compute bitwise; the result must be ready before byte index 2/5 is driven.
- Simultaneous events: STOP or START outranks any shift or ACK action in the same clk.
- SCL is never held low (no clock stretching).

Test Plan:
- Write 0x88, 0xE0, STOP with Temp_Data=16'hBEEF → both bytes ACKed, Cmd_Accepted pulses once, Busy=1 for exactly 1000 clk.
- Read 0x89 while Busy=1 → address NACKed (SDA high on 9th SCL), state returns to IDLE after STOP.
- After Busy falls, read 0x89, ACK 5 bytes, NACK the 6th, with T=16'hBEEF and RH=16'h6666 → bytes BE EF 92 66 66 93, Read_Done pulses once.
- Write 0x88, then 0xFD → command byte NACKed, Busy stays 0.
- Address 0x90 (0x48 W) → no ACK, SDA never driven.
- Reset_N low during T_lsb transmission → Sda_Out=1 on the next clk; a following read is NACKed because nothing is latched.
